axi4_rd_arb2: RTL
=================

Name: axi4_rd_arb2

Overview:
- Two-requester AXI4 read-channel arbiter that shares one downstream AXI4 read port (for example, an axi4 register slice or the fabric) between two upstream read masters.
- AR channel:
  - Round-robin arbitration, gated by a per-requester outstanding-burst limit.
  - Registered output, one-entry buffer.
- ID extension: one source bit is appended as the ID MSB so read data can be routed back.
- R channel: combinational demux on the ID MSB.

Parameters:
- ID_WIDTH, 4: upstream ID width. Downstream ID is ID_WIDTH+1.
- DATA_WIDTH, 32: R data width.
- AR_PLD_WIDTH, 61: packed AR payload {addr,len,size,burst,lock,cache,prot,region,qos,user}. The arbiter passes it through opaquely.
- MAX_OUTST, 8: maximum outstanding AR bursts per requester, 1..255.
- CNT_WIDTH, $clog2(MAX_OUTST+1): outstanding counter width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- s_arvalid  in  2  AR valid per requester; bit i = requester i.
- s_arready  out  2  AR ready per requester.
- s_arid  in  2*ID_WIDTH  AR ID; slice i = requester i.
- s_arpld  in  2*AR_PLD_WIDTH  AR payload per requester.
- s_rvalid  out  2  R valid per requester.
- s_rready  in  2  R ready per requester.
- s_rid  out  ID_WIDTH  R ID, broadcast to both requesters.
- s_rdata  out  DATA_WIDTH  R data, broadcast.
- s_rresp  out  2  R resp, broadcast.
- s_rlast  out  1  R last, broadcast.
- m_arvalid  out  1  downstream AR valid.
- m_arready  in  1  downstream AR ready.
- m_arid  out  ID_WIDTH+1  {source, s_arid}.
- m_arpld  out  AR_PLD_WIDTH  downstream AR payload.
- m_rvalid  in  1  downstream R valid.
- m_rready  out  1  downstream R ready.
- m_rid  in  ID_WIDTH+1  downstream R ID; MSB = source.
- m_rdata  in  DATA_WIDTH.
- m_rresp  in  2.
- m_rlast  in  1.

Interface: one clock (aclk); reset is asynchronous and active-low (aresetn).

Behaviour:
- Reset values:
  - m_arvalid=0; m_arid and m_arpld=0.
  - Both outstanding counters=0.
  - Round-robin pointer=0, meaning requester 0 has priority first.
  - s_arready=0 while aresetn is low.
- AR buffer states:
  - EMPTY (m_arvalid=0) and FULL (m_arvalid=1).
  - can_load = EMPTY | (FULL & m_arready).
- Eligibility: requester i is eligible when s_arvalid[i] & (cnt[i] < MAX_OUTST).
- Grant:
  - Issued only when can_load and at least one requester is eligible.
  - If both are eligible, the pointer's requester wins.
  - If one is eligible, it wins regardless of the pointer.
  - s_arready[i] = grant[i]. It is combinational and may depend on s_arvalid; at most one bit is high.
- On grant:
  - Buffer loads {i, s_arid[i]} and s_arpld[i]. m_arvalid=1 next cycle; AR latency is exactly 1 cycle.
  - Pointer moves to the other requester.
  - cnt[i] increments.
- FULL & m_arready & no grant: buffer goes to EMPTY.
- FULL & !m_arready: m_arvalid, m_arid and m_arpld hold stable (AXI rule). No grant is issued.
- Back-to-back: a full-throughput alternating stream of one AR per cycle is sustained when m_arready=1.
- R path, zero latency, combinational:
  - s_rvalid[k] = m_rvalid & (m_rid[ID_WIDTH]==k).
  - m_rready = s_rready[m_rid[ID_WIDTH]].
  - s_rid = m_rid[ID_WIDTH-1:0]; data, resp and last are broadcast.
- Counter decrement: on m_rvalid & m_rready & m_rlast with source k, cnt[k] decrements.
  - Increment and decrement of the same counter in one cycle leave it unchanged.
  - Counters never wrap. cnt=MAX_OUTST blocks grant; cnt=0 with a decrement is a protocol error (simulation assertion) and the counter holds at 0.
- Requester stall:
  - A requester at MAX_OUTST is skipped.
  - The other requester is granted even if it does not hold the pointer; the pointer still toggles to the non-granted side.
- Reset mid-operation: a pending buffered AR is discarded and counters are cleared. The surrounding system resets synchronously to this block.

Decomposition:
- Shared package axi_arb_defs: ARB_SRC_WIDTH=1 and helper localparams for the packed AR payload field offsets (addr/len/size/burst/...), so packing/unpacking shims match the axi4 slices.
- Sub-module rd_outst_cnt (one instance per requester): saturating up/down counter with an at-limit flag.
- Arbitration and the AR buffer stay in the top module.

Test Plan:
- Reset release, both s_arvalid=1, m_arready=1 held → grants r0, r1, r0, r1 on consecutive cycles; m_arid MSB alternates 0,1,0,1; m_arvalid first high 1 cycle after first grant.
- m_arready=0 for 5 cycles with buffer FULL → s_arready=00, m_arid/m_arpld stable; m_arready=1 → next grant the same cycle.
- MAX_OUTST=2, r0 issues 2 ARs with no R → third r0 AR blocked while r1 still granted. One m_rlast beat with m_rid MSB=0 → r0 granted next cycle.
- R routing: m_rid=5'b1_0011, m_rvalid=1, s_rready=2'b01 → s_rvalid=2'b10, s_rid=4'h3, m_rready=0. Then s_rready=2'b11 → m_rready=1.
- Same-cycle AR grant and rlast completion for r1 at cnt=1 → cnt[1] stays 1.
- Assert aresetn low while FULL with cnt={3,2} → m_arvalid=0 and counters 0 immediately; after release the first grant goes to r0.

Source files
------------

// File: rtl/axi_arb_defs.sv
`default_nettype none
// ==== axi_arb_defs : shared arbiter constants and packed AR payload field map | rev 1.0 ====
package axi_arb_defs;

  localparam int ARB_SRC_WIDTH = 1;

  // Packed AR payload {addr,len,size,burst,lock,cache,prot,region,qos,user}, user in the LSBs.
  localparam int AR_USER_W   = 0;
  localparam int AR_QOS_W    = 4;
  localparam int AR_REGION_W = 4;
  localparam int AR_PROT_W   = 3;
  localparam int AR_CACHE_W  = 4;
  localparam int AR_LOCK_W   = 1;
  localparam int AR_BURST_W  = 2;
  localparam int AR_SIZE_W   = 3;
  localparam int AR_LEN_W    = 8;
  localparam int AR_ADDR_W   = 32;

  localparam int AR_USER_LSB   = 0;
  localparam int AR_QOS_LSB    = AR_USER_LSB + AR_USER_W;
  localparam int AR_REGION_LSB = AR_QOS_LSB + AR_QOS_W;
  localparam int AR_PROT_LSB   = AR_REGION_LSB + AR_REGION_W;
  localparam int AR_CACHE_LSB  = AR_PROT_LSB + AR_PROT_W;
  localparam int AR_LOCK_LSB   = AR_CACHE_LSB + AR_CACHE_W;
  localparam int AR_BURST_LSB  = AR_LOCK_LSB + AR_LOCK_W;
  localparam int AR_SIZE_LSB   = AR_BURST_LSB + AR_BURST_W;
  localparam int AR_LEN_LSB    = AR_SIZE_LSB + AR_SIZE_W;
  localparam int AR_ADDR_LSB   = AR_LEN_LSB + AR_LEN_W;
  localparam int AR_PLD_W      = AR_ADDR_LSB + AR_ADDR_W;

  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } ar_buf_state_t;

endpackage
`default_nettype wire

// File: rtl/rd_outst_cnt.sv
`default_nettype none
// ==== rd_outst_cnt : saturating outstanding-burst counter with at-limit flag | rev 1.0 ====
module rd_outst_cnt #(
  parameter int MAX_OUTST = 8,
  parameter int CNT_WIDTH = $clog2(MAX_OUTST + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic at_limit_o
);

  localparam logic [CNT_WIDTH-1:0] C_LIMIT = CNT_WIDTH'(MAX_OUTST);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; both directions saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != C_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == C_LIMIT);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec_i && (cnt_q == '0)));

endmodule
`default_nettype wire

// File: rtl/axi4_rd_arb2.sv
`default_nettype none
// ==== axi4_rd_arb2 : two-requester AXI4 read arbiter, RR + outstanding limit, 1-entry AR buffer | rev 1.0 ====
module axi4_rd_arb2
  import axi_arb_defs::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int AR_PLD_WIDTH = 61,
  parameter int MAX_OUTST    = 8,
  parameter int CNT_WIDTH    = $clog2(MAX_OUTST + 1)
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [1:0]                        s_arvalid,
  output logic [1:0]                        s_arready,
  input  logic [2*ID_WIDTH-1:0]             s_arid,
  input  logic [2*AR_PLD_WIDTH-1:0]         s_arpld,
  output logic [1:0]                        s_rvalid,
  input  logic [1:0]                        s_rready,
  output logic [ID_WIDTH-1:0]               s_rid,
  output logic [DATA_WIDTH-1:0]             s_rdata,
  output logic [1:0]                        s_rresp,
  output logic                              s_rlast,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  output logic [ID_WIDTH+ARB_SRC_WIDTH-1:0] m_arid,
  output logic [AR_PLD_WIDTH-1:0]           m_arpld,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  input  logic [ID_WIDTH+ARB_SRC_WIDTH-1:0] m_rid,
  input  logic [DATA_WIDTH-1:0]             m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rlast
);

  localparam int MID_W = ID_WIDTH + ARB_SRC_WIDTH;

  ar_buf_state_t           state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic [MID_W-1:0]        arid_q, arid_d;
  logic [AR_PLD_WIDTH-1:0] pld_q, pld_d;

  logic [1:0] w_at_limit;
  logic [1:0] w_elig;
  logic [1:0] w_grant;
  logic [1:0] w_dec;
  logic       w_can_load;
  logic       w_load;
  logic       w_src;
  logic       w_rsrc;
  logic       w_rdone;

  // Grant is masked during reset so no upstream handshake can complete.
  always_comb begin
    w_can_load = (state_q == BUF_EMPTY) || m_arready;
    w_elig     = s_arvalid & ~w_at_limit;
    w_grant    = 2'b00;
    if (aresetn && w_can_load) begin
      if (&w_elig) begin
        w_grant[ptr_q] = 1'b1;
      end else begin
        w_grant = w_elig;
      end
    end
    w_load = |w_grant;
    w_src  = w_grant[1];
  end

  assign s_arready = w_grant;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    arid_d  = arid_q;
    pld_d   = pld_q;
    case (state_q)
      BUF_EMPTY: if (w_load) state_d = BUF_FULL;
      BUF_FULL:  if (!w_load && m_arready) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
    if (w_load) begin
      ptr_d  = ~w_src;
      arid_d = w_src ? {1'b1, s_arid[2*ID_WIDTH-1:ID_WIDTH]}
                     : {1'b0, s_arid[ID_WIDTH-1:0]};
      pld_d  = w_src ? s_arpld[2*AR_PLD_WIDTH-1:AR_PLD_WIDTH]
                     : s_arpld[AR_PLD_WIDTH-1:0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= BUF_EMPTY;
      ptr_q   <= 1'b0;
      arid_q  <= '0;
      pld_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      arid_q  <= arid_d;
      pld_q   <= pld_d;
    end
  end

  assign m_arvalid = (state_q == BUF_FULL);
  assign m_arid    = arid_q;
  assign m_arpld   = pld_q;

  // R channel: route on the source bit that was appended to the AR ID.
  assign w_rsrc   = m_rid[MID_W-1];
  assign s_rvalid = {m_rvalid & w_rsrc, m_rvalid & ~w_rsrc};
  assign m_rready = s_rready[w_rsrc];
  assign s_rid    = m_rid[ID_WIDTH-1:0];
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  assign w_rdone = m_rvalid & m_rready & m_rlast;
  assign w_dec   = {w_rdone & w_rsrc, w_rdone & ~w_rsrc};

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    rd_outst_cnt #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk_i      (aclk),
      .rst_ni     (aresetn),
      .inc_i      (w_grant[i]),
      .dec_i      (w_dec[i]),
      .at_limit_o (w_at_limit[i])
    );
  end

endmodule
`default_nettype wire
